// File: rtl/fetch_controller_if.sv
// Bundles the redirect, instruction-memory and decode-side signals of the fetch controller.
// The master modport is the fetch controller; the slave modport is its surroundings.
interface fetch_controller_if #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INSTR_WIDTH = 32
);
   logic                   redirect_i;
   logic [ADDR_WIDTH-1:0]  redirect_addr_i;
   logic                   imem_req_o;
   logic [ADDR_WIDTH-1:0]  imem_addr_o;
   logic                   imem_gnt_i;
   logic                   imem_rvalid_i;
   logic [INSTR_WIDTH-1:0] imem_rdata_i;
   logic                   instr_valid_o;
   logic                   instr_ready_i;
   logic [INSTR_WIDTH-1:0] instr_o;
   logic [ADDR_WIDTH-1:0]  instr_pc_o;

   modport master (
      input  redirect_i, redirect_addr_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
      output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
   );

   modport slave (
      output redirect_i, redirect_addr_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
      input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
   );
endinterface

// File: rtl/fetch_controller.sv
// Fetch-side PC sequencer: one outstanding imem request at a time, fetched word held for decode.
// Redirects from execute reload the PC at any point and squash a fetch already in flight.
module fetch_controller #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
   input logic                clk,
   input logic                rst,
   fetch_controller_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      VALID
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

   state_t                 r_state;
   logic [ADDR_WIDTH-1:0]  r_pc;
   logic                   r_squash;
   logic [INSTR_WIDTH-1:0] r_instr;
   logic [ADDR_WIDTH-1:0]  r_instrPc;

   state_t                 w_nextState;
   logic [ADDR_WIDTH-1:0]  w_nextPc;
   logic                   w_nextSquash;
   logic                   w_capture;
   logic [ADDR_WIDTH-1:0]  w_target;

   assign w_target = bus.redirect_addr_i & ~ADDR_WIDTH'(3);

   // A redirect overrides the normal flow; a response already owed by memory is marked stale instead.
   always_comb begin
      w_nextState  = r_state;
      w_nextPc     = r_pc;
      w_nextSquash = r_squash;
      w_capture    = 1'b0;
      case (r_state)
         IDLE: begin
            w_nextState = REQ;
         end
         REQ: begin
            if (bus.redirect_i) begin
               w_nextPc = w_target;
            end
            if (bus.imem_gnt_i) begin
               w_nextState  = WAIT;
               w_nextSquash = bus.redirect_i;
            end
         end
         WAIT: begin
            if (bus.redirect_i) begin
               w_nextPc = w_target;
               if (bus.imem_rvalid_i) begin
                  w_nextSquash = 1'b0;
                  w_nextState  = REQ;
               end else begin
                  w_nextSquash = 1'b1;
               end
            end else if (bus.imem_rvalid_i) begin
               if (r_squash) begin
                  w_nextSquash = 1'b0;
                  w_nextState  = REQ;
               end else begin
                  w_capture   = 1'b1;
                  w_nextPc    = r_pc + PC_STEP;
                  w_nextState = VALID;
               end
            end
         end
         VALID: begin
            if (bus.redirect_i) begin
               w_nextPc    = w_target;
               w_nextState = REQ;
            end else if (bus.instr_ready_i) begin
               w_nextState = REQ;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_pc      <= RESET_ADDR;
         r_squash  <= 1'b0;
         r_instr   <= '0;
         r_instrPc <= '0;
      end else begin
         r_state  <= w_nextState;
         r_pc     <= w_nextPc;
         r_squash <= w_nextSquash;
         if (w_capture) begin
            r_instr   <= bus.imem_rdata_i;
            r_instrPc <= r_pc;
         end
      end
   end

   assign bus.imem_req_o    = (r_state == REQ);
   assign bus.imem_addr_o   = r_pc;
   assign bus.instr_valid_o = (r_state == VALID);
   assign bus.instr_o       = r_instr;
   assign bus.instr_pc_o    = r_instrPc;

endmodule
